// File: rtl/arm_imm_encoder.sv
// Iterative search for an ARM data-processing immediate {rotate_imm, immed_8} that
// reproduces a 32-bit constant, optionally falling back to an encoding of ~value (MVN).
module arm_imm_encoder #(
  parameter int ROTS_PER_CYCLE = 1,
  parameter int CHECK_INVERTED = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        encodable,
  output logic        inverted,
  output logic [11:0] shift_operand,
  output logic [1:0]  dbg_state
);

  // Handshake: start is taken only in IDLE, with value sampled on that same edge;
  // done is a one-cycle pulse and the result outputs are valid from it until the
  // next accepted start. start seen in SEARCH or DONE is dropped, not queued.
  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] value_q, value_d;
  logic [3:0]  r_q, r_d;
  logic        inv_found_q, inv_found_d;
  logic [11:0] inv_so_q, inv_so_d;
  logic        enc_q, enc_d;
  logic        inv_q, inv_d;
  logic [11:0] so_q, so_d;

  logic [4:0]  r_next;
  logic        last_grp;
  logic        dir_hit, grp_inv_hit;
  logic [11:0] dir_so, grp_inv_so;
  logic [3:0]  rot;
  logic [31:0] cand, cand_n;

  // Rotate left by 2*r; a shift by 32 yields zero, which covers r == 0.
  function automatic logic [31:0] rol2(input logic [31:0] v, input logic [3:0] r);
    logic [5:0] sh;
    sh = {1'b0, r, 1'b0};
    return (v << sh) | (v >> (6'd32 - sh));
  endfunction

  assign r_next   = {1'b0, r_q} + 5'(ROTS_PER_CYCLE);
  assign last_grp = r_next[4];

  // Test this cycle's group of rotations; the lowest hit of each kind wins.
  always_comb begin
    dir_hit     = 1'b0;
    dir_so      = '0;
    grp_inv_hit = 1'b0;
    grp_inv_so  = '0;
    rot         = '0;
    cand        = '0;
    cand_n      = '0;
    for (int g = 0; g < ROTS_PER_CYCLE; g++) begin
      rot    = r_q + 4'(g);
      cand   = rol2(value_q, rot);
      cand_n = rol2(~value_q, rot);
      if (!dir_hit && cand[31:8] == 24'd0) begin
        dir_hit = 1'b1;
        dir_so  = {rot, cand[7:0]};
      end
      if (CHECK_INVERTED != 0 && !grp_inv_hit && cand_n[31:8] == 24'd0) begin
        grp_inv_hit = 1'b1;
        grp_inv_so  = {rot, cand_n[7:0]};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    r_d         = r_q;
    inv_found_d = inv_found_q;
    inv_so_d    = inv_so_q;
    enc_d       = enc_q;
    inv_d       = inv_q;
    so_d        = so_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          value_d     = value;
          r_d         = '0;
          inv_found_d = 1'b0;
          inv_so_d    = '0;
          state_d     = SEARCH;
        end
      end
      SEARCH: begin
        if (grp_inv_hit && !inv_found_q) begin
          inv_found_d = 1'b1;
          inv_so_d    = grp_inv_so;
        end
        if (dir_hit) begin
          enc_d   = 1'b1;
          inv_d   = 1'b0;
          so_d    = dir_so;
          state_d = DONE;
        end else if (last_grp) begin
          if (inv_found_q || grp_inv_hit) begin
            enc_d = 1'b1;
            inv_d = 1'b1;
            so_d  = inv_found_q ? inv_so_q : grp_inv_so;
          end else begin
            enc_d = 1'b0;
            inv_d = 1'b0;
            so_d  = '0;
          end
          state_d = DONE;
        end else begin
          r_d = r_next[3:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      value_q     <= '0;
      r_q         <= '0;
      inv_found_q <= 1'b0;
      inv_so_q    <= '0;
      enc_q       <= 1'b0;
      inv_q       <= 1'b0;
      so_q        <= '0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      r_q         <= r_d;
      inv_found_q <= inv_found_d;
      inv_so_q    <= inv_so_d;
      enc_q       <= enc_d;
      inv_q       <= inv_d;
      so_q        <= so_d;
    end
  end

  assign busy          = (state_q == SEARCH);
  assign done          = (state_q == DONE);
  assign encodable     = enc_q;
  assign inverted      = inv_q;
  assign shift_operand = so_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Bench for arm_imm_encoder: four instances (R=1/CI=1, R=1/CI=0, R=4, R=16) share one
// request stream; hand vectors are checked on the first, a reference encoder checks all.
module tb_arm_imm_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic [3:0]  busy_w, done_w, enc_w, inv_w;
  logic [11:0] so_w [4];
  logic [1:0]  st_w [4];

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [11:0] prev_so [4];
  bit          prev_enc [4];

  localparam int RPC [4] = '{1, 1, 4, 16};
  localparam int CI  [4] = '{1, 0, 1, 1};

  for (genvar d = 0; d < 4; d++) begin : g_dut
    arm_imm_encoder #(
      .ROTS_PER_CYCLE(RPC[d]),
      .CHECK_INVERTED(CI[d])
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .value        (value),
      .busy         (busy_w[d]),
      .done         (done_w[d]),
      .encodable    (enc_w[d]),
      .inverted     (inv_w[d]),
      .shift_operand(so_w[d]),
      .dbg_state    (st_w[d])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic [31:0] rol_m(input logic [31:0] v, input int r);
    logic [63:0] dd;
    dd = {v, v};
    return dd[63 - 2*r -: 32];
  endfunction

  // Reference encoder: direct search first, then ~value, lowest rotation wins.
  function automatic void model(input logic [31:0] v, input int ci, input int rpc,
                                output bit enc, output bit inv, output logic [11:0] so,
                                output int lat);
    logic [31:0] c;
    enc = 1'b0; inv = 1'b0; so = '0; lat = 1 + 16 / rpc;
    for (int r = 0; r < 16; r++) begin
      c = rol_m(v, r);
      if (c[31:8] == 24'd0) begin
        enc = 1'b1; so = {4'(r), c[7:0]}; lat = 2 + r / rpc;
        return;
      end
    end
    if (ci != 0) begin
      for (int r = 0; r < 16; r++) begin
        c = rol_m(~v, r);
        if (c[31:8] == 24'd0) begin
          enc = 1'b1; inv = 1'b1; so = {4'(r), c[7:0]};
          return;
        end
      end
    end
  endfunction

  function automatic logic [31:0] decode(input logic [11:0] so);
    logic [31:0] i;
    logic [5:0]  s;
    i = {24'd0, so[7:0]};
    s = {1'b0, so[11:8], 1'b0};
    return (i >> s) | (i << (6'd32 - s));
  endfunction

  task automatic run(input logic [31:0] v, input bit glitch, input bit hand, input int h_lat,
                     input bit h_enc, input bit h_inv, input logic [11:0] h_so);
    int          lat_s [4];
    int          pulses [4];
    bit          enc_s [4], inv_s [4];
    logic [11:0] so_s [4];
    bit          m_enc, m_inv;
    logic [11:0] m_so;
    int          m_lat;
    for (int d = 0; d < 4; d++) begin
      lat_s[d] = -1; pulses[d] = 0; enc_s[d] = 0; inv_s[d] = 0; so_s[d] = '0;
    end
    value = v;
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        start = 1'b0;
        value = $urandom;
        check("busy_after_accept", 32'(busy_w[0]), 32'd1);
        check("hold_so", 32'(so_w[0]), 32'(prev_so[0]));
        check("hold_enc", 32'(enc_w[0]), 32'(prev_enc[0]));
      end
      if (glitch && k == 2) begin
        start = 1'b1;
        value = 32'h12345678;
      end
      if (glitch && k == 3) start = 1'b0;
      for (int d = 0; d < 4; d++) begin
        if (done_w[d]) begin
          pulses[d]++;
          if (lat_s[d] < 0) begin
            lat_s[d] = k; enc_s[d] = enc_w[d]; inv_s[d] = inv_w[d]; so_s[d] = so_w[d];
            check($sformatf("busy_at_done[d%0d]", d), 32'(busy_w[d]), 32'd0);
          end
        end
      end
    end
    for (int d = 0; d < 4; d++) begin
      model(v, CI[d], RPC[d], m_enc, m_inv, m_so, m_lat);
      check($sformatf("latency[d%0d] v=%h", d, v), 32'(lat_s[d]), 32'(m_lat));
      check($sformatf("encodable[d%0d] v=%h", d, v), 32'(enc_s[d]), 32'(m_enc));
      check($sformatf("inverted[d%0d] v=%h", d, v), 32'(inv_s[d]), 32'(m_inv));
      check($sformatf("shift_operand[d%0d] v=%h", d, v), 32'(so_s[d]), 32'(m_so));
      check($sformatf("done_pulses[d%0d]", d), 32'(pulses[d]), 32'd1);
      if (enc_s[d])
        check($sformatf("decode_back[d%0d] v=%h", d, v), decode(so_s[d]), inv_s[d] ? ~v : v);
      prev_so[d]  = m_so;
      prev_enc[d] = m_enc;
    end
    if (hand) begin
      check($sformatf("hand_latency v=%h", v), 32'(lat_s[0]), 32'(h_lat));
      check($sformatf("hand_encodable v=%h", v), 32'(enc_s[0]), 32'(h_enc));
      check($sformatf("hand_inverted v=%h", v), 32'(inv_s[0]), 32'(h_inv));
      check($sformatf("hand_shift_operand v=%h", v), 32'(so_s[0]), 32'(h_so));
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_outputs[d%0d]", tag, d),
            {busy_w[d], done_w[d], enc_w[d], inv_w[d], 16'(so_w[d]), 12'(st_w[d])}, 32'd0);
    end
  endtask

  typedef struct {
    logic [31:0] v;
    int          lat;
    bit          enc;
    bit          inv;
    logic [11:0] so;
    bit          glitch;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{32'h000000FF,  2, 1'b1, 1'b0, 12'h0FF, 1'b0};
    tbl[1]  = '{32'hFF000000,  6, 1'b1, 1'b0, 12'h4FF, 1'b0};
    tbl[2]  = '{32'hF000000F,  4, 1'b1, 1'b0, 12'h2FF, 1'b0};
    tbl[3]  = '{32'h000003FC, 17, 1'b1, 1'b0, 12'hFFF, 1'b0};
    tbl[4]  = '{32'hFFFFFF00, 17, 1'b1, 1'b1, 12'h0FF, 1'b0};
    tbl[5]  = '{32'h00000101, 17, 1'b0, 1'b0, 12'h000, 1'b0};
    tbl[6]  = '{32'h00000000,  2, 1'b1, 1'b0, 12'h000, 1'b0};
    tbl[7]  = '{32'hC000003F,  3, 1'b1, 1'b0, 12'h1FF, 1'b0};
    tbl[8]  = '{32'h00AB0000, 10, 1'b1, 1'b0, 12'h8AB, 1'b0};
    tbl[9]  = '{32'hFFFFFFFF, 17, 1'b1, 1'b1, 12'h000, 1'b0};
    tbl[10] = '{32'h00000104, 17, 1'b1, 1'b0, 12'hF41, 1'b0};
    tbl[11] = '{32'hFF000000,  6, 1'b1, 1'b0, 12'h4FF, 1'b1};

    for (int d = 0; d < 4; d++) begin
      prev_so[d] = '0; prev_enc[d] = 1'b0;
    end
    rst = 1'b0; start = 1'b0; value = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++)
      run(tbl[i].v, tbl[i].glitch, 1'b1, tbl[i].lat, tbl[i].enc, tbl[i].inv, tbl[i].so);

    // Reset in the middle of a miss search: everything clears, no done afterwards.
    begin
      int late_done;
      late_done = 0;
      value = 32'h00000101;
      start = 1'b1;
      for (int k = 1; k <= 5; k++) begin
        @(posedge clk);
        #1;
        if (k == 1) start = 1'b0;
      end
      check("busy_before_abort", 32'(busy_w[0]), 32'd1);
      rst = 1'b0;
      #1;
      check_all_zero("abort");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk);
        #1;
        if (done_w != 4'd0) late_done++;
      end
      check("no_done_after_abort", 32'(late_done), 32'd0);
      for (int d = 0; d < 4; d++) begin
        prev_so[d] = '0; prev_enc[d] = 1'b0;
      end
      run(32'h000000FF, 1'b0, 1'b1, 2, 1'b1, 1'b0, 12'h0FF);
    end

    // Random constants: raw, rotated immediates, and complements of rotated immediates.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] rv, imm;
      int          mode, rr;
      mode = $urandom_range(0, 2);
      imm  = {24'd0, 8'($urandom_range(0, 255))};
      rr   = $urandom_range(0, 15);
      rv   = decode({4'(rr), imm[7:0]});
      if (mode == 0) rv = $urandom;
      else if (mode == 2) rv = ~rv;
      run(rv, 1'b0, 1'b0, 0, 1'b0, 1'b0, 12'h000);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
